adder_ns: RTL and testbench
===========================

# adder_ns

Parameterized two's-complement adder built as a structural chain of full-adder cells. It has a combinational sum path plus a one-stage registered result port with valid handshake and flags. The jump unit instantiates it at WIDTH = SIZE+1 for signed program-counter offset arithmetic and uses the combinational `sum` MSB as a sign/underflow indicator. Other datapath blocks use the registered port.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..64.

- `clk`  input  1  rising-edge clock for the registered port.
- `reset`  input  1  reset reset, synchronous, active-high.
- `in_valid`  input  1  qualifies `fir_num`/`sec_num` for capture into the registered port.
- `fir_num`  input  WIDTH  first operand, two's complement.
- `sec_num`  input  WIDTH  second operand, two's complement.
- `sum`  output  WIDTH  combinational `(fir_num + sec_num) mod 2^WIDTH`.
- `carry_out`  output  1  combinational carry out of the MSB cell (unsigned overflow).
- `overflow`  output  1  combinational signed overflow.
- `sum_q`  output  WIDTH  registered `sum`.
- `carry_q`  output  1  registered `carry_out`.
- `overflow_q`  output  1  registered `overflow`.
- `out_valid`  output  1  high for one cycle when `sum_q`/flags were updated.
- `ovf_sticky`  output  1  set when any captured result had `overflow` = 1.

## Operation
- Datapath: WIDTH full-adder cells in ripple order, carry-in of cell 0 = 0.
  - Cell i: `s_i = a_i ^ b_i ^ c_i`, `c_{i+1} = a_i&b_i | c_i&(a_i^b_i)`.
  - `sum` = s[WIDTH-1:0]; `carry_out` = c_WIDTH.
- `overflow` = c_WIDTH ^ c_{WIDTH-1}, i.e. both operands have the same sign and `sum` has the opposite sign.
- No saturation. Results wrap modulo 2^WIDTH.
- The same bits are valid for unsigned interpretation; use `carry_out` for unsigned overflow.
- Combinational outputs depend only on `fir_num`/`sec_num`. They are unaffected by `clk`, `reset` and `in_valid`.
- Registered port, on each rising edge of `clk`:
  - `reset` = 1: `sum_q`, `carry_q`, `overflow_q`, `out_valid` and `ovf_sticky` all go to 0. Reset has priority over `in_valid`.
  - else `in_valid` = 1: `sum_q`/`carry_q`/`overflow_q` load the current combinational values; `out_valid` = 1; `ovf_sticky` |= `overflow`.
  - else: `out_valid` = 0; all other registers hold.
- `ovf_sticky` clears only on reset.

## Timing
- Combinational path: zero-cycle latency. Outputs settle within the same cycle; the critical path is the WIDTH-cell carry chain.
- Registered path: one-cycle latency from `in_valid` sampled high to `out_valid` high with matching `sum_q`.
- Back-to-back `in_valid` gives throughput of 1 result per cycle. `out_valid` stays high continuously and results appear in issue order.
- No backpressure: there is no ready signal, and the consumer must accept on `out_valid`.
- Reset asserted mid-stream discards the in-flight capture. The cycle after reset, `out_valid` = 0 and `sum_q` = 0.
- Reset does not gate the combinational path. `sum` remains valid during reset.

## Test plan
- WIDTH=8, 8'h7F + 8'h01 -> `sum`=8'h80, `carry_out`=0, `overflow`=1; 8'hFF + 8'h01 -> 8'h00, carry 1, overflow 0; 8'h80 + 8'h80 -> 8'h00, carry 1, overflow 1.
- WIDTH=9 (jump usage): 9'h00A + 9'h1FD (10 + -3) -> `sum`=9'h007, MSB 0, carry 1; 9'h005 + 9'h1F6 (5 + -10) -> 9'h1FB, MSB 1, carry 0.
- Registered port: drive `in_valid`=1 with 8'h12 + 8'h34 -> next cycle `out_valid`=1, `sum_q`=8'h46. Drop `in_valid` -> `out_valid`=0 and `sum_q` holds 8'h46.
- Streaming: 4 consecutive valid pairs (1+1, 2+2, 3+3, 127+1) -> `sum_q` sequence 2, 4, 6, 8'h80 on consecutive cycles. `ovf_sticky` rises with the last result and stays 1.
- Reset priority: assert `reset` and `in_valid` together -> next cycle all registered outputs 0 and `ovf_sticky`=0. Combinational `sum` still equals operand sum.
- Exhaustive WIDTH=4: all 256 operand pairs -> `sum`, `carry_out` and `overflow` match the reference model `a+b` mod 16, bit 4 of `a+b`, and the sign rule.

Source files
------------

// File: rtl/adder_ns.sv
// Ripple-carry two's-complement adder built from full-adder cells, with a
// combinational sum/flag path and a one-stage registered result port.
module adder_ns #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] fir_num,
    input  logic [WIDTH-1:0] sec_num,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
    output logic             overflow_q,
    output logic             out_valid,
    output logic             ovf_sticky
);

    // Each cell keeps its own carry nets so the chain is a clean acyclic
    // netlist rather than bits of one vector feeding each other.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic cin;
            logic cout;
            logic half;

            if (gi == 0) begin : g_first
                assign cin = 1'b0;
            end else begin : g_next
                assign cin = g_cell[gi-1].cout;
            end

            assign half    = fir_num[gi] ^ sec_num[gi];
            assign sum[gi] = half ^ cin;
            assign cout    = (fir_num[gi] & sec_num[gi]) | (cin & half);
        end
    endgenerate

    assign carry_out = g_cell[WIDTH-1].cout;
    // Carry into and out of the sign cell disagree exactly on signed overflow.
    assign overflow  = g_cell[WIDTH-1].cout ^ g_cell[WIDTH-1].cin;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            out_valid  <= 1'b0;
            ovf_sticky <= 1'b0;
        end else if (in_valid) begin
            sum_q      <= sum;
            carry_q    <= carry_out;
            overflow_q <= overflow;
            out_valid  <= 1'b1;
            ovf_sticky <= ovf_sticky | overflow;
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_ns.sv
// Scoreboard bench for adder_ns: directed vectors at WIDTH 8 and 9, an
// exhaustive WIDTH 4 sweep, and a monitor that checks the registered port.
module tb_adder_ns;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] fir8, sec8, sum8, sum_q8;
    logic       carry8, ovf8, carry_q8, ovf_q8, out_valid8, sticky8;

    logic [8:0] fir9, sec9, sum9, sum_q9;
    logic       carry9, ovf9, carry_q9, ovf_q9, out_valid9, sticky9;

    logic [3:0] fir4, sec4, sum4, sum_q4;
    logic       carry4, ovf4, carry_q4, ovf_q4, out_valid4, sticky4;

    logic       iv_off = 1'b0;

    int checks = 0;
    int errors = 0;

    // Expected registered result: {sticky, overflow, carry, sum[7:0]}
    logic [10:0] exp_q[$];
    logic        sticky_model = 1'b0;

    always #5 clk = ~clk;

    adder_ns #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .fir_num(fir8), .sec_num(sec8),
        .sum(sum8), .carry_out(carry8), .overflow(ovf8),
        .sum_q(sum_q8), .carry_q(carry_q8), .overflow_q(ovf_q8),
        .out_valid(out_valid8), .ovf_sticky(sticky8)
    );

    adder_ns #(.WIDTH(9)) u9 (
        .clk(clk), .reset(reset), .in_valid(iv_off),
        .fir_num(fir9), .sec_num(sec9),
        .sum(sum9), .carry_out(carry9), .overflow(ovf9),
        .sum_q(sum_q9), .carry_q(carry_q9), .overflow_q(ovf_q9),
        .out_valid(out_valid9), .ovf_sticky(sticky9)
    );

    adder_ns #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv_off),
        .fir_num(fir4), .sec_num(sec4),
        .sum(sum4), .carry_out(carry4), .overflow(ovf4),
        .sum_q(sum_q4), .carry_q(carry_q4), .overflow_q(ovf_q4),
        .out_valid(out_valid4), .ovf_sticky(sticky4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one valid pair; expected values are written out by hand.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic c, input logic v);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        fir8     = a;
        sec8     = b;
        #1;
        check("comb8_sum", {56'd0, sum8}, {56'd0, s});
        check("comb8_flags", {62'd0, carry8, ovf8}, {62'd0, c, v});
        sticky_model = sticky_model | v;
        exp_q.push_back({sticky_model, v, c, s});
    endtask

    task automatic idle();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Monitor: pop and compare whenever the registered port presents a result.
    always @(posedge clk) begin
        logic [10:0] e;
        #1;
        if (out_valid8) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=out_valid required=no_result sum_q=%0h", sum_q8);
            end else begin
                e = exp_q.pop_front();
                $display("RESULT sum_q=%02h carry_q=%0b overflow_q=%0b ovf_sticky=%0b",
                         sum_q8, carry_q8, ovf_q8, sticky8);
                check("sb_result", {53'd0, sticky8, ovf_q8, carry_q8, sum_q8}, {53'd0, e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] r;
        logic       v;
        reset    = 1'b1;
        in_valid = 1'b0;
        fir8 = 8'h00; sec8 = 8'h00;
        fir9 = 9'h000; sec9 = 9'h000;
        fir4 = 4'h0; sec4 = 4'h0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_regs", {52'd0, sum_q8, carry_q8, ovf_q8, out_valid8, sticky8}, 64'd0);

        // WIDTH 8 combinational corner cases
        fir8 = 8'h7F; sec8 = 8'h01; #1;
        check("w8_7f_01", {55'd0, sum8, carry8}, {55'd0, 8'h80, 1'b0});
        check("w8_7f_01_ovf", {63'd0, ovf8}, 64'd1);
        fir8 = 8'hFF; sec8 = 8'h01; #1;
        check("w8_ff_01", {54'd0, sum8, carry8, ovf8}, {54'd0, 8'h00, 1'b1, 1'b0});
        fir8 = 8'h80; sec8 = 8'h80; #1;
        check("w8_80_80", {54'd0, sum8, carry8, ovf8}, {54'd0, 8'h00, 1'b1, 1'b1});

        // WIDTH 9 jump-offset usage
        fir9 = 9'h00A; sec9 = 9'h1FD; #1;
        check("w9_10_m3", {54'd0, sum9, carry9}, {54'd0, 9'h007, 1'b1});
        check("w9_10_m3_msb", {63'd0, sum9[8]}, 64'd0);
        fir9 = 9'h005; sec9 = 9'h1F6; #1;
        check("w9_5_m10", {54'd0, sum9, carry9}, {54'd0, 9'h1FB, 1'b0});
        check("w9_5_m10_msb", {63'd0, sum9[8]}, 64'd1);

        // WIDTH 4 exhaustive sweep against an arithmetic reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                fir4 = 4'(a);
                sec4 = 4'(b);
                #1;
                r = {1'b0, fir4} + {1'b0, sec4};
                v = (fir4[3] == sec4[3]) && (r[3] != fir4[3]);
                check("w4_exhaustive", {58'd0, sum4, carry4, ovf4}, {58'd0, r[3:0], r[4], v});
            end
        end

        // Single capture, then hold
        issue(8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
        idle();
        @(posedge clk); #1;
        check("hold_valid", {63'd0, out_valid8}, 64'd0);
        check("hold_sum", {56'd0, sum_q8}, {56'd0, 8'h46});

        // Back-to-back stream
        issue(8'd1,   8'd1, 8'd2,  1'b0, 1'b0);
        issue(8'd2,   8'd2, 8'd4,  1'b0, 1'b0);
        issue(8'd3,   8'd3, 8'd6,  1'b0, 1'b0);
        issue(8'd127, 8'd1, 8'h80, 1'b0, 1'b1);
        idle();
        @(posedge clk); #1;
        check("stream_sticky_hold", {62'd0, sticky8, out_valid8}, {62'd0, 1'b1, 1'b0});

        // Reset together with in_valid: no capture, sticky cleared, comb alive
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        fir8     = 8'h7F;
        sec8     = 8'h01;
        sticky_model = 1'b0;
        #1;
        check("reset_comb_sum", {56'd0, sum8}, {56'd0, 8'h80});
        @(posedge clk); #1;
        check("reset_priority", {52'd0, sum_q8, carry_q8, ovf_q8, out_valid8, sticky8}, 64'd0);
        check("reset_comb_hold", {56'd0, sum8}, {56'd0, 8'h80});

        // Sticky restarts after reset
        issue(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        issue(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        issue(8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
